// File: rtl/int_prf_freelist.sv
`default_nettype none
// ============================================================================
//  Module   : int_prf_freelist
//  Purpose  : Free list for the integer physical register file. Grants up to
//             RENAME_WIDTH free physical indices per cycle to rename. It takes
//             back indices released at commit. On a squash it rewinds the
//             speculative allocation pointer to the committed one.
//  Ports    :
//    clk            - clock
//    rst            - synchronous, active-low reset
//    i_alloc_req    - per-lane allocation request mask
//    o_can_alloc    - at least RENAME_WIDTH entries are free
//    o_alloc_iprIdx - index granted per lane (combinational)
//    i_commit_cnt   - number of previously allocated entries retiring
//    i_free_vld     - per-lane free valid mask
//    i_free_iprIdx  - indices being returned to the list
//    i_squash       - restore speculative head to committed head
//    o_free_cnt     - speculative free count (registered)
//  Revision : 1.0  initial release
// ============================================================================
module int_prf_freelist #(
  parameter  int SIZE         = 80,
  parameter  int ARCH_NUM     = 32,
  parameter  int RENAME_WIDTH = 4,
  parameter  int COMMIT_WIDTH = 4,
  localparam int FL_SIZE      = SIZE - ARCH_NUM,
  localparam int IDXW         = $clog2(SIZE),
  localparam int CCW          = $clog2(RENAME_WIDTH + 1),
  localparam int FCW          = $clog2(FL_SIZE + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [RENAME_WIDTH-1:0]                i_alloc_req,
  output logic                                   o_can_alloc,
  output logic [RENAME_WIDTH-1:0][IDXW-1:0]      o_alloc_iprIdx,
  input  logic [CCW-1:0]                         i_commit_cnt,
  input  logic [COMMIT_WIDTH-1:0]                i_free_vld,
  input  logic [COMMIT_WIDTH-1:0][IDXW-1:0]      i_free_iprIdx,
  input  logic                                   i_squash,
  output logic [FCW-1:0]                         o_free_cnt
);

  localparam int PTRW = (FL_SIZE > 1) ? $clog2(FL_SIZE) : 1;
  // Pointer + increment needs one extra bit before the modulo fold.
  localparam int SW   = PTRW + 1;
  // Counter arithmetic headroom.
  localparam int CW   = FCW + 1;

  // Fold a pointer sum (always < 2*FL_SIZE) back into [0, FL_SIZE).
  function automatic logic [PTRW-1:0] f_wrap(input logic [SW-1:0] sum);
    logic [SW-1:0] s;
    s = sum;
    if (s >= SW'(FL_SIZE)) s = s - SW'(FL_SIZE);
    return s[PTRW-1:0];
  endfunction

  logic [FL_SIZE-1:0][IDXW-1:0] mem_q;
  logic [PTRW-1:0]              spec_head_q, spec_head_d;
  logic [PTRW-1:0]              arch_head_q, arch_head_d;
  logic [PTRW-1:0]              tail_q,      tail_d;
  logic [FCW-1:0]               spec_cnt_q,  spec_cnt_d;
  logic [FCW-1:0]               arch_cnt_q,  arch_cnt_d;

  logic [PTRW-1:0]              w_alloc_addr [RENAME_WIDTH];
  logic [PTRW-1:0]              w_free_addr  [COMMIT_WIDTH];
  logic [SW-1:0]                w_alloc_num;
  logic [SW-1:0]                w_free_num;
  logic                         w_alloc_go;

  // Each requesting lane reads the slot offset by the number of lower
  // requesting lanes, so grants are packed with no holes.
  always_comb begin
    w_alloc_num = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      w_alloc_addr[i]   = f_wrap({1'b0, spec_head_q} + w_alloc_num);
      o_alloc_iprIdx[i] = mem_q[w_alloc_addr[i]];
      if (i_alloc_req[i]) w_alloc_num = w_alloc_num + SW'(1);
    end
  end

  // Valid free lanes are compacted in lane order starting at tail.
  always_comb begin
    w_free_num = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      w_free_addr[j] = f_wrap({1'b0, tail_q} + w_free_num);
      if (i_free_vld[j]) w_free_num = w_free_num + SW'(1);
    end
  end

  assign o_can_alloc = rst && (spec_cnt_q >= FCW'(RENAME_WIDTH));
  assign o_free_cnt  = spec_cnt_q;
  assign w_alloc_go  = o_can_alloc && !i_squash;

  always_comb begin
    tail_d      = f_wrap({1'b0, tail_q} + w_free_num);
    arch_head_d = f_wrap({1'b0, arch_head_q} + SW'(i_commit_cnt));
    arch_cnt_d  = FCW'(CW'(arch_cnt_q) + CW'(w_free_num) - CW'(i_commit_cnt));
    spec_head_d = spec_head_q;
    spec_cnt_d  = FCW'(CW'(spec_cnt_q) + CW'(w_free_num));
    if (i_squash) begin
      // Rewind to the committed state, including this cycle's commit/free.
      spec_head_d = arch_head_d;
      spec_cnt_d  = arch_cnt_d;
    end else if (w_alloc_go) begin
      spec_head_d = f_wrap({1'b0, spec_head_q} + w_alloc_num);
      spec_cnt_d  = FCW'(CW'(spec_cnt_q) + CW'(w_free_num) - CW'(w_alloc_num));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < FL_SIZE; k++) begin
        mem_q[k] <= IDXW'(ARCH_NUM + k);
      end
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= '0;
      spec_cnt_q  <= FCW'(FL_SIZE);
      arch_cnt_q  <= FCW'(FL_SIZE);
    end else begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (i_free_vld[j]) mem_q[w_free_addr[j]] <= i_free_iprIdx[j];
      end
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      spec_cnt_q  <= spec_cnt_d;
      arch_cnt_q  <= arch_cnt_d;
    end
  end

`ifndef SYNTHESIS
  // arch_cnt - spec_cnt is the number of granted-but-uncommitted entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (i_free_vld[j]) begin
          assert (i_free_iprIdx[j] != '0)
            else $error("int_prf_freelist: free of p0 on lane %0d", j);
        end
      end
      assert (CW'(arch_cnt_q) + CW'(w_free_num) <= CW'(FL_SIZE) + CW'(i_commit_cnt))
        else $error("int_prf_freelist: free count overflow");
      assert (CW'(i_commit_cnt) <= CW'(arch_cnt_q) - CW'(spec_cnt_q))
        else $error("int_prf_freelist: commit passes speculative head");
    end
  end
`endif

endmodule
`default_nettype wire
